reg_file_sb: RTL

Parametrised integer register file with a configurable number of asynchronous read ports, a byte-enabled synchronous write port, and optional write-to-read bypass. It also has an integrated pending-write scoreboard that tracks registers reserved by in-flight instructions. It sits in the decode/writeback stage of the RISC-V datapath, replacing the fixed-size register file. It feeds operand data and hazard flags to the issue logic.

---
 rtl/reg_file_sb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised register file with byte-enabled write, bypass and pending-write scoreboard
//
// Purpose: integer register file for the decode/writeback stage. NUM_RD
// asynchronous read ports, one synchronous byte-enabled write port, an
// optional same-cycle write-to-read bypass, and a scoreboard of registers
// reserved by in-flight instructions.
//
// Ports:
//   CLK, RESET          clock; synchronous active-high reset
//   RD_ADDR / RD_DATA   packed read ports, port i at [i*W +: W]
//   RD_PEND             per read port: addressed register has a pending write
//   WR_EN / WR_ADDR / WR_DATA / WR_BE   write port, byte enables per 8 bits
//   RSV_EN / RSV_ADDR   reserve a register (mark pending)
//   PEND_CNT            registered popcount of the pending vector

module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [NUM_RD*ADDR_W-1:0]   RD_ADDR,
   output logic [NUM_RD*DATA_W-1:0]   RD_DATA,
   output logic [NUM_RD-1:0]          RD_PEND,
   input  logic                       WR_EN,
   input  logic [ADDR_W-1:0]          WR_ADDR,
   input  logic [DATA_W-1:0]          WR_DATA,
   input  logic [DATA_W/8-1:0]        WR_BE,
   input  logic                       RSV_EN,
   input  logic [ADDR_W-1:0]          RSV_ADDR,
   output logic [ADDR_W:0]            PEND_CNT
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int NB    = DATA_W / 8;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q;
   logic [DEPTH-1:0]  pend_d;
   logic [ADDR_W:0]   pend_cnt_q;
   logic [ADDR_W:0]   pend_cnt_d;
   logic [DATA_W-1:0] wr_mask;
   logic              wr_ok;
   logic              rsv_ok;

   // Register 0 swallows writes and reservations when hardwired to zero.
   assign wr_ok  = WR_EN  && !((ZERO_REG != 0) && (WR_ADDR  == '0));
   assign rsv_ok = RSV_EN && !((ZERO_REG != 0) && (RSV_ADDR == '0));

   // Byte enables expanded to a bit mask, shared by the array write and the bypass.
   always_comb begin
      wr_mask = '0;
      for (int k = 0; k < NB; k++) begin
         wr_mask[8*k +: 8] = {8{WR_BE[k]}};
      end
   end

   // ---------------------------------------------------------------- storage
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         regs_q[WR_ADDR] <= (regs_q[WR_ADDR] & ~wr_mask) | (WR_DATA & wr_mask);
      end
   end

   // ------------------------------------------------------------- scoreboard
   // Reservation is applied after the write clear so that a same-address
   // reserve+write leaves the bit set: the reservation belongs to a newer producer.
   always_comb begin
      pend_d = pend_q;
      if (WR_EN) begin
         pend_d[WR_ADDR] = 1'b0;
      end
      if (rsv_ok) begin
         pend_d[RSV_ADDR] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         pend_d[0] = 1'b0;
      end
   end

   // Count computed from the next-state vector so PEND_CNT tracks pend_q exactly.
   always_comb begin
      pend_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pend_d[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign PEND_CNT = pend_cnt_q;

   // ------------------------------------------------------------- read ports
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] stored;
      logic [DATA_W-1:0] rdata;
      logic              hit;
      logic              is_zero;

      assign ra      = RD_ADDR[p*ADDR_W +: ADDR_W];
      assign stored  = regs_q[ra];
      assign is_zero = (ZERO_REG != 0) && (ra == '0);
      // A same-cycle write to the read address both forwards its enabled
      // bytes and resolves the hazard, so the pending flag is masked too.
      assign hit     = (BYPASS != 0) && WR_EN && (WR_ADDR == ra);

      always_comb begin
         rdata = stored;
         if (is_zero) begin
            rdata = '0;
         end else if (hit) begin
            rdata = (stored & ~wr_mask) | (WR_DATA & wr_mask);
         end
      end

      assign RD_DATA[p*DATA_W +: DATA_W] = rdata;
      assign RD_PEND[p]                  = pend_q[ra] && !hit && !is_zero;
   end

endmodule
